mem_stage_pl: RTL and testbench
===============================

Name: mem_stage_pl

Overview:
- Parametrised memory stage for the Y86-64 pipeline, placed between the M and W pipeline registers.
- Generalises the single-cycle data-memory stage:
  - configurable data width, memory depth and access latency (multi-cycle memory with a stall request to upstream);
  - W-register bubble/stall control;
  - synchronous reset.
- Produces m_valM/m_stat for forwarding and drives the W pipeline register.

Parameters:
- DATA_W, 64: data word width and width of valA/valE/valM.
- DEPTH, 1024: number of DATA_W-bit words in the data memory.
- LATENCY, 1: cycles per memory access, counted from the first cycle the op is valid in M; legal range 1..15.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- M_icode  in  4  instruction code in M.
- M_valA  in  DATA_W  valA from M.
- M_valE  in  DATA_W  valE from M.
- M_dstE  in  4  destination register for valE.
- M_dstM  in  4  destination register for valM.
- M_stat  in  2  status from M: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- W_stall  in  1  hold the W register.
- W_bubble  in  1  load a bubble into W; wins over W_stall.
- mem_busy  out  1  combinational; access in progress; upstream must hold the M register and stall F/D/E.
- m_valM  out  DATA_W  combinational read data, used for forwarding.
- m_stat  out  2  combinational stage status.
- W_icode  out  4  W register.
- W_valE  out  DATA_W  W register.
- W_valM  out  DATA_W  W register.
- W_dstE  out  4  W register.
- W_dstM  out  4  W register.
- W_stat  out  2  W register.

Behaviour:
- Op decode:
  - writes: rmmovq(4), call(8), pushq(10).
  - reads: mrmovq(5), ret(9), popq(11).
  - all other icodes: no access, mem_busy=0, m_valM=0.
- Address source: M_valE for icodes 4, 5, 8, 10; M_valA for 9, 11.
- Word index = address. Out of range when address >= DEPTH, with the address treated as unsigned.
- dmem_error:
  - asserted for an out-of-range memory op; no read or write is performed.
  - m_stat = 2 (ADR) when dmem_error and M_stat==0; otherwise m_stat = M_stat.
  - dmem_error is combinational per instruction and never sticky.
- Mem ops are suppressed when M_stat != 0 (no write, m_valM=0, mem_busy=0).
- Access timing:
  - cnt counts 0..LATENCY-1; done = (cnt == LATENCY-1).
  - mem_busy = valid mem op && !done.
  - cnt increments each cycle while mem_busy and saturates at done.
  - cnt clears to 0 when W accepts the instruction (W_stall=0), or on rst.
  - LATENCY=1 means done immediately, with zero busy cycles.
- Read: m_valM = mem[index] when done, else 0.
- Write:
  - committed at the posedge where done && !W_stall && !W_bubble && !rst.
  - exactly once per instruction; a stalled done store does not rewrite.
- W register update, on posedge, in priority order:
  1. rst or W_bubble: icode=1 (nop), stat=0, dstE=dstM=4'hF, valE=valM=0.
  2. W_stall: hold.
  3. mem_busy: bubble, as in step 1.
  4. Otherwise load M_icode, M_valE, m_valM, M_dstE, M_dstM, m_stat.
- Memory contents are not reset.
- Reset mid-access: cnt cleared, no write committed, W holds a bubble.

Optional Feature:
- MEM_BYTE_ADDR_EN defined:
  - byte addressing; index = address >> log2(DATA_W/8).
  - range check is index >= DEPTH.
  - a misaligned address (low bits != 0) sets ADR with no access.
- Undefined: word addressing as described above, with no alignment check.

Decomposition:
- Package y86_pkg holds:
  - icode constants: NOP=1, RMMOVQ=4, MRMOVQ=5, CALL=8, RET=9, PUSHQ=10, POPQ=11;
  - stat constants: AOK, HLT, ADR, INS;
  - RNONE=4'hF.
- Natural sub-module: data_mem_array, containing the DEPTH x DATA_W storage, a combinational read port, a synchronous write-enable port and the range check.

Test Plan:
- rmmovq, LATENCY=1: valA=0x55, valE=16, then mrmovq valE=16 → m_valM=0x55, W_valM=0x55 the next cycle, mem_busy never high.
- LATENCY=3, mrmovq valE=8 → mem_busy high for 2 cycles, W receives 2 bubbles (icode 1), then W_valM=mem[8].
- pushq valE=1024 with DEPTH=1024 → m_stat=2, W_stat=2, no write (mem[0..1023] unchanged); the same op with M_stat=1 → W_stat=1.
- Done store with W_stall high for 3 cycles → single write, W holds; release → W loads; mem value correct and written once.
- rst during the second busy cycle of rmmovq at LATENCY=3 → target word unchanged, W=nop/AOK, cnt=0; reissue completes after 3 cycles.
- MEM_BYTE_ADDR_EN: mrmovq valE=12 → ADR; valE=24 → reads word index 3.

Source files
------------

// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 constants and small decode helpers used by the memory stage.
//   - icode constants (NOP, RMMOVQ, MRMOVQ, CALL, RET, PUSHQ, POPQ)
//   - stat constants (AOK, HLT, ADR, INS)
//   - RNONE register id
//   - mem_acc_e: kind of data-memory access an instruction performs
//   - decode_access(): icode -> access kind
//   - addr_from_vala(): icode -> 1 when the address comes from valA
// -----------------------------------------------------------------------------
package y86_pkg;

    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [1:0] AOK = 2'd0;
    localparam logic [1:0] HLT = 2'd1;
    localparam logic [1:0] ADR = 2'd2;
    localparam logic [1:0] INS = 2'd3;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } mem_acc_e;

    // Classify an icode by the data-memory access it performs.
    function automatic mem_acc_e decode_access(input logic [3:0] icode);
        mem_acc_e acc;
        case (icode)
            RMMOVQ, CALL, PUSHQ: acc = ACC_WRITE;
            MRMOVQ, RET, POPQ:   acc = ACC_READ;
            default:             acc = ACC_NONE;
        endcase
        return acc;
    endfunction

    // ret and popq address the stack through valA (old %rsp); all others use valE.
    function automatic logic addr_from_vala(input logic [3:0] icode);
        logic sel;
        case (icode)
            RET, POPQ: sel = 1'b1;
            default:   sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mem_stage_pl_data_mem_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// DEPTH x DATA_W data memory with a combinational read port, a synchronous
// write port and an address legality check. Contents are never reset.
//
// Optional feature macro: MEM_BYTE_ADDR_EN
//   undefined : addr is a word index, no alignment check
//   defined   : addr is a byte address; index = addr >> log2(DATA_W/8),
//               a non-zero low byte offset is flagged as an address error
//
// Ports
//   clk      in   clock, rising edge
//   addr     in   DATA_W  address (unsigned)
//   we       in   write enable (ignored when addr_err)
//   wdata    in   DATA_W  write data
//   rdata    out  DATA_W  read data, zero when addr_err
//   addr_err out  address out of range (or misaligned in byte mode)
// -----------------------------------------------------------------------------
module data_mem_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] word_idx_s;
    logic [IDX_W-1:0]  idx_s;
    logic              out_of_range_s;
    logic              misaligned_s;

`ifdef MEM_BYTE_ADDR_EN
    localparam int BYTE_SH = $clog2(DATA_W / 8);

    assign word_idx_s   = addr >> BYTE_SH;
    assign misaligned_s = (addr[BYTE_SH-1:0] != {BYTE_SH{1'b0}});
`else
    assign word_idx_s   = addr;
    assign misaligned_s = 1'b0;
`endif

    // Full-width unsigned compare so high address bits can never alias into range.
    assign out_of_range_s = (word_idx_s >= DATA_W'(DEPTH));
    assign idx_s          = word_idx_s[IDX_W-1:0];
    assign addr_err       = out_of_range_s | misaligned_s;

    // Combinational read port; illegal addresses read as zero.
    always_comb begin
        rdata = {DATA_W{1'b0}};
        if (!addr_err) begin
            rdata = mem_r[idx_s];
        end else begin
            rdata = {DATA_W{1'b0}};
        end
    end

    // Synchronous write port; illegal addresses never touch the array.
    always_ff @(posedge clk) begin
        if (we && !addr_err) begin
            mem_r[idx_s] <= wdata;
        end
    end

endmodule

// File: rtl/mem_stage_pl.sv
// -----------------------------------------------------------------------------
// mem_stage_pl
// Y86-64 memory stage between the M and W pipeline registers, with a
// configurable multi-cycle data memory and W-register stall/bubble control.
//
// Optional feature macro: MEM_BYTE_ADDR_EN (byte addressing + alignment check,
// handled inside data_mem_array).
//
// Parameters
//   DATA_W   data word width (valA/valE/valM)
//   DEPTH    number of DATA_W words in the data memory
//   LATENCY  cycles per memory access, 1..15
//
// Ports
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   M_icode/M_valA/M_valE      instruction fields from the M register
//   M_dstE/M_dstM/M_stat
//   W_stall, W_bubble          W register control (bubble wins)
//   mem_busy                   comb: access in progress, upstream must hold M
//   m_valM, m_stat             comb: forwarding values
//   W_icode..W_stat            W pipeline register
// -----------------------------------------------------------------------------
module mem_stage_pl
    import y86_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        M_icode,
    input  logic [DATA_W-1:0] M_valA,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [1:0]        M_stat,
    input  logic              W_stall,
    input  logic              W_bubble,
    output logic              mem_busy,
    output logic [DATA_W-1:0] m_valM,
    output logic [1:0]        m_stat,
    output logic [3:0]        W_icode,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM,
    output logic [1:0]        W_stat
);

    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("mem_stage_pl: LATENCY must be in 1..15");
        end
    endgenerate

    mem_acc_e          acc_s;
    logic              is_mem_s;
    logic              valid_op_s;
    logic              dmem_error_s;
    logic              done_s;
    logic              we_s;
    logic              addr_err_s;
    logic [DATA_W-1:0] addr_s;
    logic [DATA_W-1:0] rdata_s;
    logic [3:0]        cnt_r;

    assign acc_s    = decode_access(M_icode);
    assign is_mem_s = (acc_s != ACC_NONE);
    assign done_s   = (cnt_r == LAST_CNT);

    // Address mux: stack pops read through valA, everything else through valE.
    always_comb begin
        addr_s = M_valE;
        if (addr_from_vala(M_icode)) begin
            addr_s = M_valA;
        end else begin
            addr_s = M_valE;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk      (clk),
        .addr     (addr_s),
        .we       (we_s),
        .wdata    (M_valA),
        .rdata    (rdata_s),
        .addr_err (addr_err_s)
    );

    // Access qualification: a faulted or already-excepting instruction never
    // touches memory and never stalls the pipe.
    always_comb begin
        dmem_error_s = is_mem_s && addr_err_s;
        valid_op_s   = is_mem_s && (M_stat == AOK) && !addr_err_s;
        // The store commits only on the edge where W takes the instruction,
        // so a stalled store cannot be written twice.
        we_s = valid_op_s && (acc_s == ACC_WRITE) && done_s
               && !W_stall && !W_bubble && !rst;
    end

    // Forwarding outputs and stall request.
    always_comb begin
        mem_busy = valid_op_s && !done_s;
        m_valM   = {DATA_W{1'b0}};
        if (valid_op_s && done_s && (acc_s == ACC_READ)) begin
            m_valM = rdata_s;
        end else begin
            m_valM = {DATA_W{1'b0}};
        end
        if (dmem_error_s && (M_stat == AOK)) begin
            m_stat = ADR;
        end else begin
            m_stat = M_stat;
        end
    end

    // Access cycle counter: advances while busy, saturates at done, clears
    // once W accepts the instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (mem_busy) begin
            cnt_r <= cnt_r + 4'd1;
        end else if (!W_stall) begin
            cnt_r <= 4'd0;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // W pipeline register: reset/bubble, then stall, then busy-bubble, then load.
    always_ff @(posedge clk) begin
        if (rst || W_bubble) begin
            W_icode <= NOP;
            W_valE  <= {DATA_W{1'b0}};
            W_valM  <= {DATA_W{1'b0}};
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
            W_stat  <= AOK;
        end else if (W_stall) begin
            W_icode <= W_icode;
            W_valE  <= W_valE;
            W_valM  <= W_valM;
            W_dstE  <= W_dstE;
            W_dstM  <= W_dstM;
            W_stat  <= W_stat;
        end else if (mem_busy) begin
            W_icode <= NOP;
            W_valE  <= {DATA_W{1'b0}};
            W_valM  <= {DATA_W{1'b0}};
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
            W_stat  <= AOK;
        end else begin
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
            W_stat  <= m_stat;
        end
    end

endmodule

// File: tb/tb_mem_stage_pl.sv
// Directed, scoreboard-based bench for mem_stage_pl. Instance a uses
// LATENCY=1, instance b uses LATENCY=3; sel_b routes the instruction to one
// of them while the other sees a nop.
module tb_mem_stage_pl;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode;
    logic        sel_b;
    logic [63:0] valA, valE;
    logic [3:0]  dstE, dstM;
    logic [1:0]  stat;
    logic        W_stall, W_bubble;

    logic [3:0]  icode_a, icode_b;
    logic        busy_a, busy_b;
    logic [63:0] mvalM_a, mvalM_b, WvalE_a, WvalE_b, WvalM_a, WvalM_b;
    logic [1:0]  mstat_a, mstat_b, Wstat_a, Wstat_b;
    logic [3:0]  Wicode_a, Wicode_b, WdstE_a, WdstE_b, WdstM_a, WdstM_b;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    string       tag_q[$];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    assign icode_a = sel_b ? NOP : icode;
    assign icode_b = sel_b ? icode : NOP;

    mem_stage_pl #(.DATA_W(64), .DEPTH(1024), .LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst), .M_icode(icode_a), .M_valA(valA), .M_valE(valE),
        .M_dstE(dstE), .M_dstM(dstM), .M_stat(stat), .W_stall(W_stall),
        .W_bubble(W_bubble), .mem_busy(busy_a), .m_valM(mvalM_a), .m_stat(mstat_a),
        .W_icode(Wicode_a), .W_valE(WvalE_a), .W_valM(WvalM_a), .W_dstE(WdstE_a),
        .W_dstM(WdstM_a), .W_stat(Wstat_a));

    mem_stage_pl #(.DATA_W(64), .DEPTH(1024), .LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst), .M_icode(icode_b), .M_valA(valA), .M_valE(valE),
        .M_dstE(dstE), .M_dstM(dstM), .M_stat(stat), .W_stall(W_stall),
        .W_bubble(W_bubble), .mem_busy(busy_b), .m_valM(mvalM_b), .m_stat(mstat_b),
        .W_icode(Wicode_b), .W_valE(WvalE_b), .W_valM(WvalM_b), .W_dstE(WdstE_b),
        .W_dstM(WdstM_b), .W_stat(Wstat_b));

    // Address of word w in the configured addressing mode.
    function automatic logic [63:0] waddr(input int w);
`ifdef MEM_BYTE_ADDR_EN
        return 64'(w) * 64'd8;
`else
        return 64'(w);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply an instruction to M, then let combinational outputs settle.
    task automatic drive(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [3:0] de, input logic [3:0] dm, input logic [1:0] st);
        icode = ic; valA = a; valE = e; dstE = de; dstM = dm; stat = st;
        #1;
    endtask

    task automatic expv(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [63:0] obs);
        string       tag;
        logic [63:0] e;
        total_cnt++;
        if (exp_q.size() == 0) begin
            fail_cnt++;
            $error("FAIL scoreboard_underflow: observed %h required <none>", obs);
        end else begin
            tag = tag_q.pop_front();
            e   = exp_q.pop_front();
            assert (obs === e) begin
                pass_cnt++;
            end else begin
                fail_cnt++;
                $error("FAIL %s: observed %h required %h", tag, obs, e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; sel_b = 1'b0; W_stall = 1'b0; W_bubble = 1'b0;
        drive(NOP, 64'd0, 64'd0, RNONE, RNONE, AOK);
        tick(); tick();
        rst = 1'b0;

        // ---- reset state
        expv("rst_W_icode_a", 64'(NOP));   chk(64'(Wicode_a));
        expv("rst_W_stat_a", 64'(AOK));    chk(64'(Wstat_a));
        expv("rst_W_dstE_a", 64'(RNONE));  chk(64'(WdstE_a));
        expv("rst_W_valM_b", 64'd0);       chk(WvalM_b);
        expv("rst_W_dstM_b", 64'(RNONE));  chk(64'(WdstM_b));

        // ---- LATENCY=1: store then load
        drive(RMMOVQ, 64'h55, waddr(16), RNONE, RNONE, AOK);
        expv("st_busy", 64'd0); expv("st_mstat", 64'(AOK));
        expv("st_W_icode", 64'(RMMOVQ)); expv("st_W_valE", waddr(16));
        chk(64'(busy_a)); chk(64'(mstat_a));
        tick(); chk(64'(Wicode_a)); chk(WvalE_a);

        drive(MRMOVQ, 64'd0, waddr(16), RNONE, 4'd3, AOK);
        expv("ld_busy", 64'd0); expv("ld_m_valM", 64'h55);
        expv("ld_W_valM", 64'h55); expv("ld_W_dstM", 64'd3); expv("ld_W_icode", 64'(MRMOVQ));
        chk(64'(busy_a)); chk(mvalM_a);
        tick(); chk(WvalM_a); chk(64'(WdstM_a)); chk(64'(Wicode_a));

        // ---- popq reads through valA; call/ret pair
        drive(POPQ, waddr(16), waddr(5), 4'd4, 4'd1, AOK);
        expv("popq_m_valM", 64'h55); expv("popq_W_valE", waddr(5));
        chk(mvalM_a);
        tick(); chk(WvalE_a);
        drive(CALL, 64'hCA11, waddr(20), 4'd4, RNONE, AOK);
        tick();
        drive(RET, waddr(20), waddr(21), 4'd4, RNONE, AOK);
        expv("ret_m_valM", 64'hCA11); chk(mvalM_a);
        tick();

        // ---- non-memory op and suppressed read
        drive(NOP, 64'd0, waddr(16), RNONE, RNONE, AOK);
        expv("nop_m_valM", 64'd0); chk(mvalM_a);
        tick();
        drive(MRMOVQ, 64'd0, waddr(16), RNONE, 4'd2, HLT);
        expv("hlt_rd_m_valM", 64'd0); expv("hlt_rd_m_stat", 64'(HLT));
        chk(mvalM_a); chk(64'(mstat_a));
        tick();

        // ---- out-of-range: prewrite word 0 so an aliasing write is visible
        drive(RMMOVQ, 64'h1111, waddr(0), RNONE, RNONE, AOK);
        tick();
        drive(PUSHQ, 64'hDEAD, waddr(1024), 4'd4, RNONE, AOK);
        expv("oor_m_stat", 64'(ADR)); expv("oor_busy", 64'd0); expv("oor_W_stat", 64'(ADR));
        chk(64'(mstat_a)); chk(64'(busy_a));
        tick(); chk(64'(Wstat_a));
        drive(PUSHQ, 64'hDEAD, waddr(1024), 4'd4, RNONE, HLT);
        expv("oor_hlt_m_stat", 64'(HLT)); expv("oor_hlt_W_stat", 64'(HLT));
        chk(64'(mstat_a));
        tick(); chk(64'(Wstat_a));
        drive(MRMOVQ, 64'd0, waddr(1024), RNONE, 4'd1, AOK);
        expv("oor_rd_m_valM", 64'd0); expv("oor_rd_m_stat", 64'(ADR));
        chk(mvalM_a); chk(64'(mstat_a));
        tick();
        drive(MRMOVQ, 64'd0, waddr(0), RNONE, 4'd1, AOK);
        expv("word0_intact", 64'h1111); chk(mvalM_a);
        tick();

        // ---- done store held by W_stall for 3 cycles
        drive(RMMOVQ, 64'h30, waddr(30), RNONE, RNONE, AOK);
        tick();
        drive(NOP, 64'd0, 64'h123, RNONE, RNONE, AOK);
        tick();
        W_stall = 1'b1;
        drive(RMMOVQ, 64'h77, waddr(30), RNONE, RNONE, AOK);
        expv("stall_busy", 64'd0); chk(64'(busy_a));
        for (int i = 0; i < 3; i++) begin
            tick();
            expv("stall_W_hold_icode", 64'(NOP)); chk(64'(Wicode_a));
            expv("stall_W_hold_valE", 64'h123);   chk(WvalE_a);
            expv("stall_no_write", 64'h30);       chk(u_dut_a.u_mem.mem_r[30]);
        end
        W_stall = 1'b0;
        #1;
        expv("release_W_icode", 64'(RMMOVQ)); expv("release_mem", 64'h77);
        tick(); chk(64'(Wicode_a)); chk(u_dut_a.u_mem.mem_r[30]);

        // ---- W_bubble squashes a done store
        W_bubble = 1'b1;
        drive(RMMOVQ, 64'hBB, waddr(30), RNONE, RNONE, AOK);
        expv("bubble_W_icode", 64'(NOP)); expv("bubble_no_write", 64'h77);
        tick(); chk(64'(Wicode_a)); chk(u_dut_a.u_mem.mem_r[30]);
        W_bubble = 1'b0;
        drive(NOP, 64'd0, 64'd0, RNONE, RNONE, AOK);
        tick();

`ifdef MEM_BYTE_ADDR_EN
        // ---- byte addressing: misaligned and aligned accesses
        drive(RMMOVQ, 64'h333, 64'd24, RNONE, RNONE, AOK);
        tick();
        drive(MRMOVQ, 64'd0, 64'd12, RNONE, 4'd1, AOK);
        expv("byte_misalign_m_stat", 64'(ADR)); chk(64'(mstat_a));
        tick();
        drive(MRMOVQ, 64'd0, 64'd24, RNONE, 4'd1, AOK);
        expv("byte_aligned_m_valM", 64'h333); expv("byte_word3", 64'h333);
        chk(mvalM_a); chk(u_dut_a.u_mem.mem_r[3]);
        tick();
`endif

        // ---- LATENCY=3: store word 8, then load it
        sel_b = 1'b1;
        drive(RMMOVQ, 64'h88, waddr(8), RNONE, RNONE, AOK);
        expv("l3_st_busy0", 64'd1); chk(64'(busy_b));
        tick(); expv("l3_st_W_bub0", 64'(NOP)); expv("l3_st_busy1", 64'd1);
        chk(64'(Wicode_b)); chk(64'(busy_b));
        tick(); expv("l3_st_W_bub1", 64'(NOP)); expv("l3_st_busy2", 64'd0);
        chk(64'(Wicode_b)); chk(64'(busy_b));
        tick(); expv("l3_st_W_icode", 64'(RMMOVQ)); chk(64'(Wicode_b));

        drive(MRMOVQ, 64'd0, waddr(8), RNONE, 4'd2, AOK);
        expv("l3_ld_busy0", 64'd1); expv("l3_ld_valM0", 64'd0);
        chk(64'(busy_b)); chk(mvalM_b);
        tick(); expv("l3_ld_W_bub0", 64'(NOP)); chk(64'(Wicode_b));
        tick(); expv("l3_ld_W_bub1", 64'(NOP)); expv("l3_ld_busy2", 64'd0); expv("l3_ld_valM2", 64'h88);
        chk(64'(Wicode_b)); chk(64'(busy_b)); chk(mvalM_b);
        tick(); expv("l3_ld_W_valM", 64'h88); expv("l3_ld_W_icode", 64'(MRMOVQ));
        chk(WvalM_b); chk(64'(Wicode_b));

        // ---- reset in the second busy cycle of a store, then reissue
        drive(RMMOVQ, 64'h99, waddr(8), RNONE, RNONE, AOK);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        expv("rstmid_W_icode", 64'(NOP)); expv("rstmid_W_stat", 64'(AOK));
        expv("rstmid_mem", 64'h88); expv("rstmid_busy_cnt0", 64'd1);
        chk(64'(Wicode_b)); chk(64'(Wstat_b)); chk(u_dut_b.u_mem.mem_r[8]); chk(64'(busy_b));
        tick(); expv("reissue_busy1", 64'd1); chk(64'(busy_b));
        tick(); expv("reissue_busy2", 64'd0); chk(64'(busy_b));
        tick(); expv("reissue_W_icode", 64'(RMMOVQ)); expv("reissue_mem", 64'h99);
        chk(64'(Wicode_b)); chk(u_dut_b.u_mem.mem_r[8]);
        drive(NOP, 64'd0, 64'd0, RNONE, RNONE, AOK);
        tick();

        if (exp_q.size() != 0) begin
            total_cnt++;
            fail_cnt++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
